// File: rtl/riscv_structures.sv
// Shared pipeline record types for the RISC-V core.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package riscv_structures;

    // Upper bound on the number of writeback sources feeding the register file.
    localparam int WB_NSRC_MAX = 8;

    // Memory-stage to writeback record.
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
        logic        reg_write;
    } mem_to_wb_s;

endpackage

// File: rtl/wb_fifo.sv
// Per-source writeback queue with per-entry visibility for the pending-register mask.
// Latency: a push is visible at head/empty one cycle later; pop takes effect on the same edge.
// Backpressure: full blocks push (even with a same-cycle pop); flush empties and blocks push.
module wb_fifo
    import riscv_structures::*;
#(
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  mem_to_wb_s       push_rec,
    output logic             full,
    output logic             empty,
    output mem_to_wb_s       head,
    output logic [4:0]       ent_rd [DEPTH],
    output logic [DEPTH-1:0] ent_vld
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    mem_to_wb_s  mem [DEPTH];

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // Pointer update: flush wins over push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

    // Storage write; contents are only meaningful where ent_vld is set, so no reset.
    always_ff @(posedge clk) begin
        if (push && !full && !flush) begin
            mem[wr_ptr[AW-1:0]] <= push_rec;
        end
    end

    // An entry is live when its distance from the read pointer is below the occupancy.
    always_comb begin
        logic [AW-1:0] off;
        off     = '0;
        ent_vld = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off        = AW'(i) - rd_ptr[AW-1:0];
            ent_vld[i] = ({1'b0, off} < count);
            ent_rd[i]  = mem[i].rd;
        end
    end

endmodule

// File: rtl/wb_arbiter.sv
// Round-robin merge of N_SRC writeback streams into one register-file write port.
// Latency: record accepted at edge E0 strobes write_back_enable in the cycle after E0+1.
// Backpressure: src_ready[i] is simply !full of that source's queue (low during reset).
module wb_arbiter
    import riscv_structures::*;
#(
    parameter int N_SRC = 3,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic [N_SRC-1:0] src_valid,
    input  mem_to_wb_s       src_req [N_SRC],
    output logic [N_SRC-1:0] src_ready,
    output logic [4:0]       writeback_address,
    output logic [31:0]      write_back_data,
    output logic             write_back_enable,
    output logic [31:0]      pending_mask
);

    localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

    logic [N_SRC-1:0] fifo_full;
    logic [N_SRC-1:0] fifo_empty;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    mem_to_wb_s       fifo_head [N_SRC];
    logic [4:0]       ent_rd    [N_SRC][DEPTH];
    logic [DEPTH-1:0] ent_vld   [N_SRC];

    logic [IW-1:0]    rr_ptr;
    logic [IW-1:0]    rr_next;
    logic             grant_vld;
    logic [IW-1:0]    grant_idx;
    mem_to_wb_s       sel_rec;

    logic             out_vld;
    logic [4:0]       out_rd;
    logic [31:0]      out_data;

    // Ready is gated by reset so nothing is offered while the block is held.
    assign src_ready = {N_SRC{rst_n}} & ~fifo_full;

    // Records that would not write a real register are consumed but never queued.
    always_comb begin
        push = '0;
        for (int i = 0; i < N_SRC; i++) begin
            push[i] = src_valid[i] && src_ready[i] && src_req[i].reg_write
                      && (src_req[i].rd != 5'd0) && !flush;
        end
    end

    for (genvar i = 0; i < N_SRC; i++) begin : g_src
        wb_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk      (clk),
            .rst_n    (rst_n),
            .push     (push[i]),
            .pop      (pop[i]),
            .flush    (flush),
            .push_rec (src_req[i]),
            .full     (fifo_full[i]),
            .empty    (fifo_empty[i]),
            .head     (fifo_head[i]),
            .ent_rd   (ent_rd[i]),
            .ent_vld  (ent_vld[i])
        );
    end

    // Round-robin pick of the first non-empty queue at or after rr_ptr; flush suppresses it.
    always_comb begin
        int s;
        int nxt;
        s         = 0;
        nxt       = 0;
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 0; k < N_SRC; k++) begin
            s = int'(rr_ptr) + k;
            if (s >= N_SRC) s = s - N_SRC;
            if (!grant_vld && !fifo_empty[s]) begin
                grant_vld = 1'b1;
                grant_idx = IW'(s);
            end
        end
        if (flush) grant_vld = 1'b0;
        nxt = int'(grant_idx) + 1;
        if (nxt >= N_SRC) nxt = 0;
        rr_next = IW'(nxt);
    end

    // One-hot pop and head mux for the granted queue.
    always_comb begin
        pop     = '0;
        sel_rec = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (grant_vld && (int'(grant_idx) == i)) begin
                pop[i]  = 1'b1;
                sel_rec = fifo_head[i];
            end
        end
    end

    // Output register and round-robin pointer; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr   <= '0;
            out_vld  <= 1'b0;
            out_rd   <= '0;
            out_data <= '0;
        end else if (grant_vld) begin
            rr_ptr   <= rr_next;
            // Queued records always have reg_write set; keep it in the strobe for safety.
            out_vld  <= sel_rec.reg_write;
            out_rd   <= sel_rec.rd;
            out_data <= sel_rec.data;
        end else begin
            out_vld  <= 1'b0;
        end
    end

    assign write_back_enable = out_vld;
    assign writeback_address = out_rd;
    assign write_back_data   = out_data;

    // Registers with a write still in flight: every live queue entry plus the output stage.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < N_SRC; i++) begin
            for (int e = 0; e < DEPTH; e++) begin
                if (ent_vld[i][e]) pending_mask[ent_rd[i][e]] = 1'b1;
            end
        end
        if (out_vld) pending_mask[out_rd] = 1'b1;
        pending_mask[0] = 1'b0;
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Randomised plus directed bench for wb_arbiter with a queue-level reference model.
// Latency: model predicts each strobe; the monitor pops the expected queue on every strobe.
// Backpressure: model tracks per-source occupancy to predict src_ready.
module tb_wb_arbiter;
    import riscv_structures::*;

    localparam int N = 3;
    localparam int D = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic [N-1:0] src_valid = '0;
    mem_to_wb_s  src_req [N];
    logic [N-1:0] src_ready;
    logic [4:0]  writeback_address;
    logic [31:0] write_back_data;
    logic        write_back_enable;
    logic [31:0] pending_mask;

    int checks = 0;
    int errors = 0;

    wb_arbiter #(.N_SRC(N), .DEPTH(D)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .flush             (flush),
        .src_valid         (src_valid),
        .src_req           (src_req),
        .src_ready         (src_ready),
        .writeback_address (writeback_address),
        .write_back_data   (write_back_data),
        .write_back_enable (write_back_enable),
        .pending_mask      (pending_mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    mem_to_wb_s mq [N][$];
    mem_to_wb_s exp_q [$];
    int         m_rr = 0;
    bit         m_vld = 0;
    logic [4:0] m_rd = '0;

    always @(posedge clk or negedge rst_n) begin
        bit         rdy [N];
        int         s;
        mem_to_wb_s r;
        if (!rst_n) begin
            for (int i = 0; i < N; i++) mq[i].delete();
            exp_q.delete();
            m_rr  = 0;
            m_vld = 0;
            m_rd  = '0;
        end else begin
            for (int i = 0; i < N; i++) rdy[i] = (mq[i].size() < D);
            if (flush) begin
                for (int i = 0; i < N; i++) mq[i].delete();
                m_vld = 0;
            end else begin
                m_vld = 0;
                for (int k = 0; k < N; k++) begin
                    s = (m_rr + k) % N;
                    if (!m_vld && mq[s].size() > 0) begin
                        r = mq[s].pop_front();
                        exp_q.push_back(r);
                        m_vld = 1;
                        m_rd  = r.rd;
                        m_rr  = (s + 1) % N;
                    end
                end
                for (int i = 0; i < N; i++) begin
                    if (src_valid[i] && rdy[i] && src_req[i].reg_write && src_req[i].rd != 5'd0)
                        mq[i].push_back(src_req[i]);
                end
            end
        end
    end

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [31:0]  emask;
        logic [N-1:0] erdy;
        mem_to_wb_s   e;
        if (rst_n) begin
            emask = '0;
            for (int i = 0; i < N; i++) begin
                erdy[i] = (mq[i].size() < D);
                foreach (mq[i][j]) emask[mq[i][j].rd] = 1'b1;
            end
            if (m_vld) emask[m_rd] = 1'b1;
            emask[0] = 1'b0;
            chk("src_ready", 64'(src_ready), 64'(erdy));
            chk("pending_mask", 64'(pending_mask), 64'(emask));
            chk("enable", 64'(write_back_enable), 64'(m_vld));
            if (write_back_enable) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 64'(writeback_address), 64'hFFFF);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_addr", 64'(writeback_address), 64'(e.rd));
                    chk("wb_data", 64'(write_back_data), 64'(e.data));
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic set_src(input int i, input logic [4:0] rd, input logic [31:0] data, input logic we);
        src_req[i].rd        = rd;
        src_req[i].data      = data;
        src_req[i].reg_write = we;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_en"},    64'(write_back_enable), 64'd0);
        chk({tag, "_addr"},  64'(writeback_address), 64'd0);
        chk({tag, "_data"},  64'(write_back_data),   64'd0);
        chk({tag, "_mask"},  64'(pending_mask),      64'd0);
        chk({tag, "_ready"}, 64'(src_ready),         64'd0);
    endtask

    // Single write on src0, check strobe lands exactly one edge after the edge following acceptance.
    task automatic latency_probe(input logic [4:0] rd, input logic [31:0] data, input string tag);
        set_src(0, rd, data, 1'b1);
        src_valid = 3'b001;
        step();                         // acceptance edge E0
        src_valid = '0;
        chk({tag, "_en_E0"},   64'(write_back_enable), 64'd0);
        chk({tag, "_pend_E0"}, 64'(pending_mask[rd]),  64'd1);
        step();                         // E0+1: popped into output register
        chk({tag, "_en_E1"},   64'(write_back_enable), 64'd1);
        chk({tag, "_addr_E1"}, 64'(writeback_address), 64'(rd));
        chk({tag, "_data_E1"}, 64'(write_back_data),   64'(data));
        chk({tag, "_pend_E1"}, 64'(pending_mask[rd]),  64'd1);
        step();
        chk({tag, "_en_E2"},   64'(write_back_enable), 64'd0);
        chk({tag, "_pend_E2"}, 64'(pending_mask),      64'd0);
    endtask

    initial begin
        for (int i = 0; i < N; i++) set_src(i, 5'd0, 32'd0, 1'b0);

        // Reset state
        #2;
        chk_reset_outputs("reset");
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        step();

        // Single write latency and pending bit
        latency_probe(5'd5, 32'hDEADBEEF, "lat");

        // All three sources continuously valid: strict 1,2,3 rotation
        set_src(0, 5'd1, 32'h1111_0000, 1'b1);
        set_src(1, 5'd2, 32'h2222_0000, 1'b1);
        set_src(2, 5'd3, 32'h3333_0000, 1'b1);
        src_valid = 3'b111;
        for (int c = 0; c < 30; c++) begin
            for (int i = 0; i < N; i++) src_req[i].data = $urandom;
            step();
        end
        src_valid = '0;
        repeat (6) step();

        // Non-writing records are consumed but produce nothing
        set_src(1, 5'd0, 32'hAAAA_5555, 1'b1);
        src_valid = 3'b010;
        step();
        set_src(1, 5'd7, 32'h5555_AAAA, 1'b0);
        step();
        src_valid = '0;
        repeat (2) step();
        chk("nowrite_en", 64'(write_back_enable), 64'd0);
        chk("nowrite_mask", 64'(pending_mask), 64'd0);

        // Queue on src2 then flush with a colliding push
        set_src(2, 5'd9, 32'h0000_0009, 1'b1);
        src_valid = 3'b100;
        step();
        set_src(2, 5'd10, 32'h0000_000A, 1'b1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        src_valid = '0;
        chk("flush_en", 64'(write_back_enable), 64'd0);
        chk("flush_mask", 64'(pending_mask), 64'd0);
        chk("flush_ready2", 64'(src_ready[2]), 64'd1);
        repeat (3) step();

        // Random traffic with occasional flushes
        for (int c = 0; c < 1500; c++) begin
            src_valid = N'($urandom);
            for (int i = 0; i < N; i++)
                set_src(i, 5'($urandom_range(0, 31)), $urandom, ($urandom_range(0, 7) != 0));
            flush = ($urandom_range(0, 31) == 0);
            step();
        end
        src_valid = '0;
        flush = 1'b0;
        repeat (6) step();

        // Asynchronous reset with several writes queued
        set_src(0, 5'd4, 32'h4444_4444, 1'b1);
        set_src(1, 5'd5, 32'h5555_5555, 1'b1);
        set_src(2, 5'd6, 32'h6666_6666, 1'b1);
        src_valid = 3'b111;
        step();
        step();
        src_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("arst");
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("arst_hold");
        #2 rst_n = 1'b1;
        #1;
        chk("arst_ready_rise", 64'(src_ready), 64'h7);
        step();
        chk("arst_no_strobe", 64'(write_back_enable), 64'd0);
        latency_probe(5'd12, 32'h0C0C_0C0C, "post_rst");

        repeat (4) step();
        chk("scoreboard_drained", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
